// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB command queue
//
// Purpose: FSM state encoding, address/data widths and the command record
//          carried through the command FIFO.
// Ports:   none (package).
package apb_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   typedef struct packed {
      logic              write;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// rtl/apb_cmd_fifo.sv - DEPTH-entry command FIFO with first-word fall-through
//
// Purpose: stores {write, addr, wdata} commands; head entry is always visible
//          on pop_data while the FIFO is non-empty.
// Ports:   pclk, preset      clock, asynchronous active-low reset
//          push, push_data   write side; push ignored while full
//          pop, pop_data     read side; pop ignored while empty
//          full, empty       occupancy flags
module apb_cmd_fifo
   import apb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic pclk,
   input  logic preset,
   input  logic push,
   input  cmd_t push_data,
   input  logic pop,
   output cmd_t pop_data,
   output logic full,
   output logic empty
);

   localparam int               PTR_W    = $clog2(DEPTH);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

   cmd_t             mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic             push_ok;
   logic             pop_ok;

   assign full     = (count == FULL_CNT);
   assign empty    = (count == '0);
   // A push while full is refused even if a pop happens on the same edge.
   assign push_ok  = push & ~full;
   assign pop_ok   = pop & ~empty;
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge pclk) begin
      if (push_ok) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH.
   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/apb_cmd_queue.sv
// rtl/apb_cmd_queue.sv - queued command front end for a simple APB master
//
// Purpose: buffers commands in apb_cmd_fifo and issues them one at a time to
//          the APB master, returning one response per command in order.
// Build option: define APB_CMD_TIMEOUT_EN to abort an ACCESS that sees no
//          pready within TIMEOUT_CYC cycles (response flagged with rsp_err).
// Ports:   pclk, preset                        clock, async active-low reset
//          cmd_valid/cmd_ready, cmd_write,
//          cmd_addr, cmd_wdata                 command input handshake
//          trans, re_wr, wr_paddr, wr_data,
//          re_paddr                            request to the APB master
//          pready, pdata                       completion and read data
//          rsp_valid/rsp_ready, rsp_rdata,
//          rsp_write, rsp_err                  response output handshake
module apb_cmd_queue
   import apb_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic              pclk,
   input  logic              preset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              trans,
   output logic              re_wr,
   output logic [ADDR_W-1:0] wr_paddr,
   output logic [DATA_W-1:0] wr_data,
   output logic [ADDR_W-1:0] re_paddr,
   input  logic              pready,
   input  logic [DATA_W-1:0] pdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_write,
   output logic              rsp_err
);

   state_t state;
   cmd_t   hold;
   cmd_t   fifo_head;
   cmd_t   cmd_in;
   logic   fifo_full;
   logic   fifo_empty;
   logic   fifo_pop;
   logic   avail_q;

   assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
   assign cmd_ready = ~fifo_full;

   // The FSM acts on a registered copy of the FIFO non-empty flag, which keeps
   // FIFO status off the FSM's combinational path and accounts for the second
   // cycle of push-to-trans latency. It cannot go stale: every pop is
   // followed by at least one ACCESS and one RESP cycle before IDLE.
   assign fifo_pop = (state == IDLE) & avail_q & ~fifo_empty;

   apb_cmd_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .pclk      (pclk),
      .preset    (preset),
      .push      (cmd_valid),
      .push_data (cmd_in),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Master-side fields come straight from the holding register, gated by the
   // registered trans, so they are stable through ACCESS and zero elsewhere.
   assign re_wr    = trans & hold.write;
   assign wr_paddr = (trans &&  hold.write) ? hold.addr  : '0;
   assign wr_data  = (trans &&  hold.write) ? hold.wdata : '0;
   assign re_paddr = (trans && !hold.write) ? hold.addr  : '0;

`ifdef APB_CMD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic             tmo_hit;
   logic             rsp_err_q;

   // Counter holds the number of completed ACCESS cycles; the edge that ends
   // cycle TIMEOUT_CYC is the one where it reads TIMEOUT_CYC-1.
   assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
   assign rsp_err = rsp_err_q;
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;

   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge pclk or negedge preset) begin
      if (!preset) begin
         state     <= IDLE;
         hold      <= '0;
         avail_q   <= 1'b0;
         trans     <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_write <= 1'b0;
`ifdef APB_CMD_TIMEOUT_EN
         tmo_cnt   <= '0;
         rsp_err_q <= 1'b0;
`endif
      end else begin
         avail_q <= ~fifo_empty;
         case (state)
            IDLE: begin
               if (fifo_pop) begin
                  hold  <= fifo_head;
                  trans <= 1'b1;
                  state <= ACCESS;
`ifdef APB_CMD_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
               end
            end
            ACCESS: begin
               // pready wins over a timeout landing on the same edge.
               if (pready) begin
                  trans     <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_write <= hold.write;
                  rsp_rdata <= hold.write ? '0 : pdata;
                  state     <= RESP;
`ifdef APB_CMD_TIMEOUT_EN
                  rsp_err_q <= 1'b0;
               end else if (tmo_hit) begin
                  trans     <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_write <= hold.write;
                  rsp_rdata <= '0;
                  rsp_err_q <= 1'b1;
                  state     <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
`endif
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               trans     <= 1'b0;
               rsp_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_cmd_queue.sv
// tb/tb_apb_cmd_queue.sv - scoreboard bench for apb_cmd_queue
module tb_apb_cmd_queue;

   localparam int DEPTH       = 4;
   localparam int TIMEOUT_CYC = 15;

   logic       pclk;
   logic       preset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       trans;
   logic       re_wr;
   logic [7:0] wr_paddr;
   logic [7:0] wr_data;
   logic [7:0] re_paddr;
   logic       pready;
   logic [7:0] pdata;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_rdata;
   logic       rsp_write;
   logic       rsp_err;

   int          n_checks;
   int          n_err;
   logic [24:0] exp_cmd[$];
   logic [9:0]  exp_rsp[$];
   int          last_len;
   int          pr_delay;
   bit          pr_hold;
   bit          pr_spur;

   apb_cmd_queue #(
      .DEPTH       (DEPTH),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .pclk      (pclk),
      .preset    (preset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .trans     (trans),
      .re_wr     (re_wr),
      .wr_paddr  (wr_paddr),
      .wr_data   (wr_data),
      .re_paddr  (re_paddr),
      .pready    (pready),
      .pdata     (pdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_write (rsp_write),
      .rsp_err   (rsp_err)
   );

   initial begin
      pclk = 1'b0;
      forever #5 pclk = ~pclk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion earlier");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Read data returned by the APB side is a fixed function of the address.
   initial begin
      int acc;
      acc    = 0;
      pready = 1'b0;
      pdata  = 8'h00;
      forever begin
         @(negedge pclk);
         if (trans) acc++;
         else       acc = 0;
         pready = pr_spur || (trans && !pr_hold && acc > pr_delay);
         pdata  = re_paddr ^ 8'h7E;
      end
   end

   // Master-side monitor: each rising trans pops an expected command.
   initial begin
      logic        tr_prev;
      logic [24:0] first;
      logic [24:0] cur;
      int          tr_len;
      tr_prev = 1'b0;
      first   = '0;
      tr_len  = 0;
      forever begin
         @(negedge pclk);
         cur = {re_wr, wr_paddr, wr_data, re_paddr};
         if (!preset) begin
            tr_prev = 1'b0;
         end else begin
            if (trans && !tr_prev) begin
               if (exp_cmd.size() == 0) begin
                  n_checks++;
                  n_err++;
                  $display("FAIL apb_unexpected: actual=%0h required=no transfer", cur);
               end else begin
                  check("apb_cmd", cur, exp_cmd.pop_front());
               end
               first  = cur;
               tr_len = 1;
            end else if (trans) begin
               check("apb_stable", cur, first);
               tr_len++;
            end
            if (!trans && tr_prev) last_len = tr_len;
            tr_prev = trans;
         end
      end
   end

   // Response monitor: each completed handshake pops an expected response.
   initial begin
      forever begin
         @(negedge pclk);
         if (preset && rsp_valid && rsp_ready) begin
            if (exp_rsp.size() == 0) begin
               n_checks++;
               n_err++;
               $display("FAIL rsp_unexpected: actual=%0h required=no response",
                        {rsp_write, rsp_rdata, rsp_err});
            end else begin
               check("rsp", {rsp_write, rsp_rdata, rsp_err}, exp_rsp.pop_front());
               check("rsp_trans_low", trans, 1'b0);
            end
         end
      end
   end

   task automatic push(input bit w, input logic [7:0] a, input logic [7:0] d);
      int n;
      n = 0;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      cmd_valid = 1'b1;
      while (!cmd_ready && n < 200) begin
         @(negedge pclk);
         n++;
      end
      check("push_accept", cmd_ready, 1'b1);
      exp_cmd.push_back({w, w ? a : 8'h00, w ? d : 8'h00, w ? 8'h00 : a});
      exp_rsp.push_back({w, w ? 8'h00 : (a ^ 8'h7E), 1'b0});
      @(posedge pclk);
      #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_rsp.size() != 0 || exp_cmd.size() != 0) && n < 500) begin
         @(negedge pclk);
         n++;
      end
      check("drain_in_time", (n < 500), 1'b1);
      repeat (2) @(negedge pclk);
   endtask

   initial begin
      logic [9:0] held;
      int         n;
      n_checks  = 0;
      n_err     = 0;
      last_len  = 0;
      pr_delay  = 0;
      pr_hold   = 1'b0;
      pr_spur   = 1'b0;
      preset    = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_addr  = 8'h00;
      cmd_wdata = 8'h00;
      rsp_ready = 1'b1;

      // Reset state
      #12;
      check("rst_trans", trans, 1'b0);
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_rsp_flags", {rsp_err, rsp_write}, 2'b00);
      check("rst_data_outs", {re_wr, wr_paddr, wr_data, re_paddr, rsp_rdata}, 33'h0);
      @(negedge pclk);
      preset = 1'b1;
      @(negedge pclk);
      check("rst_cmd_ready", cmd_ready, 1'b1);

      // Single write with push-to-trans latency and trans length
      pr_delay = 2;
      push(1'b1, 8'h10, 8'hA5);
      @(negedge pclk);
      check("lat_after_n", trans, 1'b0);
      @(negedge pclk);
      check("lat_after_n1", trans, 1'b0);
      @(negedge pclk);
      check("lat_after_n2", trans, 1'b1);
      wait_drain();
      check("wr_trans_len", last_len, 3);

      // Single read
      pr_delay = 1;
      push(1'b0, 8'h22, 8'h00);
      wait_drain();

      // pready outside ACCESS is ignored
      pr_spur = 1'b1;
      repeat (3) begin
         @(negedge pclk);
         check("spur_no_rsp", {trans, rsp_valid}, 2'b00);
      end
      pr_spur = 1'b0;
      @(negedge pclk);

      // Full FIFO: one in the holding register plus DEPTH queued
      pr_hold  = 1'b1;
      pr_delay = 0;
      push(1'b1, 8'h30, 8'h11);
      push(1'b0, 8'h31, 8'h00);
      push(1'b1, 8'h32, 8'h22);
      push(1'b0, 8'h33, 8'h00);
      push(1'b1, 8'h34, 8'h44);
      check("full_ready_low", cmd_ready, 1'b0);
      check("full_trans_busy", trans, 1'b1);
      cmd_write = 1'b1;
      cmd_addr  = 8'h35;
      cmd_wdata = 8'h55;
      cmd_valid = 1'b1;
      @(posedge pclk);
      #1;
      cmd_valid = 1'b0;
      check("full_refused", cmd_ready, 1'b0);
      pr_hold = 1'b0;
      wait_drain();

      // Response backpressure
      pr_delay = 1;
      @(posedge pclk);
      #1;
      rsp_ready = 1'b0;
      push(1'b0, 8'h40, 8'h00);
      push(1'b1, 8'h41, 8'h66);
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge pclk);
         n++;
      end
      check("bp_rsp_seen", rsp_valid, 1'b1);
      held = {rsp_write, rsp_rdata, rsp_err};
      repeat (4) begin
         @(negedge pclk);
         check("bp_hold", {rsp_valid, trans, rsp_write, rsp_rdata, rsp_err}, {2'b10, held});
      end
      @(posedge pclk);
      #1;
      rsp_ready = 1'b1;
      wait_drain();

      // Reset during ACCESS abandons the transaction and empties the FIFO
      pr_hold = 1'b1;
      push(1'b1, 8'h50, 8'h77);
      push(1'b0, 8'h51, 8'h00);
      n = 0;
      while (!trans && n < 50) begin
         @(negedge pclk);
         n++;
      end
      check("mid_trans_seen", trans, 1'b1);
      @(negedge pclk);
      #3;
      preset = 1'b0;
      #1;
      check("mid_rst_outs", {trans, rsp_valid}, 2'b00);
      exp_cmd.delete();
      exp_rsp.delete();
      pr_hold = 1'b0;
      @(negedge pclk);
      preset = 1'b1;
      repeat (5) begin
         @(negedge pclk);
         check("mid_rst_idle", {trans, rsp_valid}, 2'b00);
      end
      check("mid_rst_ready", cmd_ready, 1'b1);

      // No pready: timeout build aborts, default build keeps waiting
      pr_hold = 1'b1;
      push(1'b0, 8'h60, 8'h00);
`ifdef APB_CMD_TIMEOUT_EN
      void'(exp_rsp.pop_back());
      exp_rsp.push_back({1'b0, 8'h00, 1'b1});
      wait_drain();
      check("tmo_access_len", last_len, TIMEOUT_CYC);
      pr_hold = 1'b0;
`else
      repeat (40) @(negedge pclk);
      check("wait_forever", {trans, rsp_valid}, 2'b10);
      pr_hold = 1'b0;
      wait_drain();
`endif

      check("leftover_rsp", exp_rsp.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/apb_cmd_queue.md
APB_CMD_QUEUE -- requirements
Module: apb_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO entries, power of two, 2..16.
REQ-002 Parameter TIMEOUT_CYC, default 15: maximum cycles to wait for pready; used only with APB_CMD_TIMEOUT_EN.
REQ-003 pclk  in  1  single clock; all logic on rising edge.
REQ-004 preset  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid / cmd_ready  in / out  1 / 1  command handshake; a command transfers when both are high.
REQ-006 cmd_write  in  1  command type: 1 = write, 0 = read.
REQ-007 cmd_addr / cmd_wdata  in  8 / 8  command address and write data.
REQ-008 trans  out  1  transfer request to the APB master.
REQ-009 re_wr  out  1  master direction: 1 = write, 0 = read.
REQ-010 wr_paddr / wr_data / re_paddr  out  8 / 8 / 8  master write address, write data and read address.
REQ-011 pready / pdata  in  1 / 8  completion and read data returned from the APB side.
REQ-012 rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-013 rsp_rdata  out  8  read data, 0 for writes.
REQ-014 rsp_write / rsp_err  out  1 / 1  response type echo and timeout flag.

Function
REQ-015 FIFO shall hold DEPTH commands {write, addr, wdata}.
- cmd_ready = not full.
- Simultaneous push and pop when full: push is refused that cycle.
- Simultaneous push and pop when neither full nor empty: both happen and count is unchanged.
REQ-016 FSM states and transitions:
- IDLE to ACCESS when the FIFO is non-empty; the head is popped into a holding register.
- ACCESS to RESP when pready is sampled high.
- RESP to IDLE when rsp_ready is high.
REQ-017 In ACCESS, trans shall be 1, with re_wr, wr_paddr, wr_data and re_paddr driven from the holding register and held stable.
- For reads, wr_paddr and wr_data shall be 0.
- For writes, re_paddr shall be 0.
- trans shall be 0 in every other state.
REQ-018 Latency: a command pushed into an empty FIFO at edge N, with the FSM in IDLE, shall see trans high after edge N+2.
REQ-019 At the edge where pready is sampled high in ACCESS:
- rsp_rdata captures pdata for reads, or 0 for writes.
- rsp_write captures the command type.
- rsp_err = 0.
REQ-020 rsp_valid shall be 1 exactly while in RESP; rsp fields shall stay stable until the handshake completes.
REQ-021 Commands shall issue strictly in FIFO order, one outstanding at a time; a new command cannot be popped before the previous response handshake completes.
REQ-022 pready while not in ACCESS shall be ignored.
REQ-023 Wrap-around: FIFO pointers are log2(DEPTH) bits wide and wrap modulo DEPTH; the occupancy counter is log2(DEPTH)+1 bits wide.

Reset
REQ-024 While preset = 0, regardless of clock:
- FSM goes to IDLE and the FIFO is emptied.
- trans, rsp_valid, rsp_err, rsp_write = 0.
- All address/data outputs and rsp_rdata = 0.
- cmd_ready = 1 once reset is released.
REQ-025 Reset during ACCESS or RESP shall abandon the transaction with no response.

Configuration
REQ-026 With APB_CMD_TIMEOUT_EN defined:
- A cycle counter runs in ACCESS, cleared on entry.
- If pready has not been sampled high after TIMEOUT_CYC cycles, the FSM enters RESP with rsp_err = 1 and rsp_rdata = 0, and trans drops.
- pready arriving on the same edge as the timeout takes priority (rsp_err = 0).
REQ-027 Without APB_CMD_TIMEOUT_EN, no counter exists, ACCESS waits for pready indefinitely, and rsp_err is tied to 0.

Structure
REQ-028 A shared package apb_pkg shall hold the FSM state encoding (IDLE, ACCESS, RESP), the ADDR_W = 8 and DATA_W = 8 constants, and the command record layout.
REQ-029 The FIFO shall be a sub-module named apb_cmd_fifo (parameter DEPTH, push/pop/full/empty); the FSM and timeout logic stay in apb_cmd_queue.

Verification
REQ-030 Single write:
- Stimulus: push write addr 0x10, data 0xA5; pready returned 2 cycles after trans rises.
- Response: trans is high for 3 cycles, with re_wr = 1, wr_paddr = 0x10, wr_data = 0xA5.
- Then rsp_valid = 1 with rsp_write = 1 and rsp_rdata = 0x00.
REQ-031 Single read:
- Stimulus: push read addr 0x22; pdata = 0x5C at pready.
- Response: re_paddr = 0x22 and re_wr = 0 during ACCESS; rsp_rdata = 0x5C, rsp_err = 0.
REQ-032 Full FIFO (DEPTH = 4):
- Stimulus: push 5 commands back-to-back with pready held low.
- Response: cmd_ready = 0 after the 5th push is accepted (1 in the holding register plus 4 in the FIFO); the 6th push is refused.
- All 5 commands later complete in order.
REQ-033 Response backpressure: hold rsp_ready = 0 for 4 cycles -> the FSM stays in RESP, trans stays 0 and rsp fields stay stable; rsp_ready = 1 -> the next command issues.
REQ-034 Reset mid-operation: assert preset = 0 asynchronously during ACCESS -> trans = 0 and rsp_valid = 0 immediately; after release the FIFO is empty and cmd_ready = 1.
REQ-035 Timeout (APB_CMD_TIMEOUT_EN defined, TIMEOUT_CYC = 15): never assert pready -> after 15 ACCESS cycles rsp_valid = 1 and rsp_err = 1; a build without the macro waits indefinitely.
